// File: rtl/lg_6_1.sv
// -----------------------------------------------------------------------------
// lg_6_1 : clocked OR-gate unit
//
// Produces a registered 2-input OR (Y1 = A | B) and a registered 4-input OR
// (Y2 = A | B | C | D). Each input may be asynchronous to CLK, so every input
// first passes through its own SYNC_STAGES-deep flop chain before the OR and
// the output register. Input-to-output latency is SYNC_STAGES + 1 rising edges.
//
// Parameters
//   SYNC_STAGES : synchronizer flops per input, legal range 0..4
//                 (0 = inputs sampled directly by the output register)
//
// Ports
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset (clears chains and outputs)
//   A, B   in   operands feeding both Y1 and Y2
//   C, D   in   operands feeding Y2 only
//   Y1     out  registered A | B
//   Y2     out  registered A | B | C | D
// -----------------------------------------------------------------------------
module lg_6_1 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic Y1,
   output logic Y2
);

   // Bit order inside the synchronizer vectors: {D, C, B, A}.
   logic [3:0] din;
   logic [3:0] dsync;

   assign din = {D, C, B, A};

   generate
      if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_cfg
         $error("lg_6_1: SYNC_STAGES=%0d is outside the legal range 0..4", SYNC_STAGES);
      end

      if (SYNC_STAGES == 0) begin : g_direct
         assign dsync = din;
      end else begin : g_sync
         // Each input has its own chain; the four bits share a stage register
         // only for compactness, they are not synchronized as a group.
         for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_stage
            logic [3:0] d;
            logic [3:0] q;

            if (s == 0) begin : g_first
               assign d = din;
            end else begin : g_next
               assign d = g_stage[s-1].q;
            end

            // NOTE: every synchronizer flop is reset, so no stale pre-reset
            // sample can reach the outputs after reset is released.
            always_ff @(posedge CLK or negedge RST_N) begin
               if (!RST_N) begin
                  q <= '0;
               end else begin
                  // NOTE: non-blocking assignment keeps each stage sampling the
                  // previous stage's old value, which is what forms the chain.
                  q <= d;
               end
            end
         end

         assign dsync = g_stage[SYNC_STAGES-1].q;
      end
   endgenerate

   // Output register: both ORs are computed from the same synchronized
   // sample, so Y1 = 1 always implies Y2 = 1, including during reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Y1 <= 1'b0;
         Y2 <= 1'b0;
      end else begin
         Y1 <= dsync[0] | dsync[1];
         Y2 <= |dsync;
      end
   end

endmodule

// File: tb/tb_lg_6_1.sv
// -----------------------------------------------------------------------------
// tb_lg_6_1 : directed self-checking bench for lg_6_1
//
// Three instances (SYNC_STAGES = 0, 2, 4) share one set of inputs. After each
// input change the bench checks, per instance, that the outputs still hold the
// old result one edge before the expected latency and show the new result at
// exactly the expected latency. Expected results come from hand-written
// constants; the Y1 -> Y2 implication is checked on every sampled cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lg_6_1;

   localparam int N_DUT = 3;

   logic clk;
   logic rst_n;
   logic a, b, c, d;
   logic y1 [N_DUT];
   logic y2 [N_DUT];

   // Latency (SYNC_STAGES + 1) of each instance.
   int lat [N_DUT] = '{1, 3, 5};

   // Hand-computed truth tables indexed by {A,B,C,D}:
   // Y1 is 1 whenever A or B is set (index >= 4); Y2 is 1 for any nonzero index.
   logic [15:0] y1_tab = 16'hFFF0;
   logic [15:0] y2_tab = 16'hFFFE;

   logic prev_y1;
   logic prev_y2;

   int n_checks = 0;
   int n_pass   = 0;

   lg_6_1 #(.SYNC_STAGES(0)) u_dut_s0 (
      .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .C(c), .D(d), .Y1(y1[0]), .Y2(y2[0])
   );
   lg_6_1 #(.SYNC_STAGES(2)) u_dut_s2 (
      .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .C(c), .D(d), .Y1(y1[1]), .Y2(y2[1])
   );
   lg_6_1 #(.SYNC_STAGES(4)) u_dut_s4 (
      .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .C(c), .D(d), .Y1(y1[2]), .Y2(y2[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic actual, input logic expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %b, expected %b (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Called just after the posedge on which the inputs (or reset) changed.
   // Samples on falling edges: k counts rising edges taken since the change.
   task automatic settle(input string name, input logic new_y1, input logic new_y2);
      @(negedge clk);
      for (int k = 0; k <= 5; k++) begin
         for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("%s inv L%0d k%0d", name, lat[i], k), y1[i] & ~y2[i], 1'b0);
            if (k == lat[i] - 1) begin
               check($sformatf("%s y1 old L%0d", name, lat[i]), y1[i], prev_y1);
               check($sformatf("%s y2 old L%0d", name, lat[i]), y2[i], prev_y2);
            end
            if (k == lat[i]) begin
               check($sformatf("%s y1 new L%0d", name, lat[i]), y1[i], new_y1);
               check($sformatf("%s y2 new L%0d", name, lat[i]), y2[i], new_y2);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      prev_y1 = new_y1;
      prev_y2 = new_y2;
   endtask

   task automatic apply(input logic [3:0] v);
      @(posedge clk);
      #1;
      {a, b, c, d} = v;
      settle($sformatf("vec%b", v), y1_tab[v], y2_tab[v]);
   endtask

   initial begin
      // Reset held with all inputs high: outputs must stay 0.
      rst_n = 1'b0;
      {a, b, c, d} = 4'b1111;
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         check($sformatf("rst async y1 L%0d", lat[i]), y1[i], 1'b0);
         check($sformatf("rst async y2 L%0d", lat[i]), y2[i], 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("rst hold y1 L%0d", lat[i]), y1[i], 1'b0);
            check($sformatf("rst hold y2 L%0d", lat[i]), y2[i], 1'b0);
         end
      end

      // Release: outputs rise to 1 after exactly SYNC_STAGES + 1 edges.
      prev_y1 = 1'b0;
      prev_y2 = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle("rst release", 1'b1, 1'b1);

      // All zero (held well over 100 ns across apply + extra cycles).
      apply(4'b0000);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("zero hold y1 L%0d", lat[i]), y1[i], 1'b0);
            check($sformatf("zero hold y2 L%0d", lat[i]), y2[i], 1'b0);
         end
      end

      // Directed 2-input and 4-input cases.
      apply(4'b1100);
      apply(4'b0000);
      apply(4'b1000);
      apply(4'b0000);
      apply(4'b0100);
      apply(4'b0001);
      apply(4'b1101);

      // Exhaustive sweep of all 16 combinations.
      for (int v = 0; v < 16; v++) begin
         apply(4'(v));
      end

      // Mid-operation sub-cycle reset pulse while Y2 = 1 (inputs 1111 settled).
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         check($sformatf("mid rst y1 L%0d", lat[i]), y1[i], 1'b0);
         check($sformatf("mid rst y2 L%0d", lat[i]), y2[i], 1'b0);
      end
      #1;
      rst_n = 1'b1;
      prev_y1 = 1'b0;
      prev_y2 = 1'b0;
      settle("mid rst refill", 1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Bound on total run time in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected completion within 100 us");
      $fatal(1, "timeout");
   end

endmodule
